// File: rtl/clk_div.sv
// Programmable integer clock divider: clk_out = clk_in / ratio, ratio changed by req/ack handshake at period boundaries.
// Optional CLK_DIV_TICK_EN adds tick_out, a one-cycle pulse at the start of each clk_out high phase.
module clk_div #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_req,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick_out
`endif
);

  localparam logic [DIV_W-1:0] LP_RST_RATIO = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] LP_ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] LP_TWO       = DIV_W'(2);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_ratio;
  logic             r_clk_out;
  logic             r_ack;
  logic             r_err;

  logic             w_boundary;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_ratio_nxt;
  logic             w_ack_nxt;
  logic             w_err_nxt;
  logic [DIV_W:0]   w_ratio_p1;
  logic [DIV_W:0]   w_hi_nxt;
  logic             w_clk_nxt;

  // clk_out is derived from the next-state cnt/ratio so it stays in lockstep with cnt without a decode after the flop.
  always_comb begin
    w_boundary  = (r_cnt == (r_ratio - LP_ONE));
    w_cnt_nxt   = r_cnt + LP_ONE;
    w_ratio_nxt = r_ratio;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_boundary) begin
      w_cnt_nxt = '0;
      if (div_req) begin
        w_ack_nxt = 1'b1;
        if (div_val >= LP_TWO) begin
          w_ratio_nxt = div_val;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
    end
    w_ratio_p1 = {1'b0, w_ratio_nxt} + (DIV_W+1)'(1);
    w_hi_nxt   = w_ratio_p1 >> 1;
    w_clk_nxt  = ({1'b0, w_cnt_nxt} < w_hi_nxt);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt     <= LP_RST_RATIO - LP_ONE;
      r_ratio   <= LP_RST_RATIO;
      r_clk_out <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_ratio   <= w_ratio_nxt;
      r_clk_out <= w_clk_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign div_ack = r_ack;
  assign div_err = r_err;
  assign cur_div = r_ratio;
  assign clk_out = r_clk_out;

`ifdef CLK_DIV_TICK_EN
  logic r_tick;
  logic w_tick_nxt;

  always_comb begin
    w_tick_nxt = (w_cnt_nxt == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
    end
  end

  assign tick_out = r_tick;
`endif

endmodule

// File: tb/tb_clk_div.sv
// Directed self-checking bench for clk_div (DIV_W=8, DIV_RESET=2); tick_out checks when CLK_DIV_TICK_EN is defined.
module tb_clk_div;

  logic       clk_in;
  logic       rst;
  logic [7:0] div_val;
  logic       div_req;
  logic       div_ack;
  logic       div_err;
  logic [7:0] cur_div;
  logic       clk_out;
`ifdef CLK_DIV_TICK_EN
  logic       tick_out;
`endif

  int checks;
  int failures;
  int n;

  int exp_rel[4]  = '{1, 0, 1, 0};
  int exp5[10]    = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int exp_rs[6]   = '{1, 0, 1, 0, 1, 0};
  int exp3_clk[5] = '{1, 0, 1, 1, 0};
  int exp3_tck[5] = '{0, 0, 1, 0, 0};

  clk_div #(
    .DIV_W    (8),
    .DIV_RESET(2)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div_val (div_val),
    .div_req (div_req),
    .div_ack (div_ack),
    .div_err (div_err),
    .cur_div (cur_div),
    .clk_out (clk_out)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick_out(tick_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    div_req  = 1'b0;
    div_val  = 8'd0;

    repeat (3) begin
      step();
      check("rst_clk", clk_out, 0);
      check("rst_div", cur_div, 2);
      check("rst_ack", div_ack, 0);
`ifdef CLK_DIV_TICK_EN
      check("rst_tick", tick_out, 0);
`endif
    end

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rel_clk", clk_out, exp_rel[i]);
      check("rel_ack", div_ack, 0);
    end

    // cnt=1 of ratio 2: next edge is the boundary
    div_req = 1'b1;
    div_val = 8'd5;
    step();
    check("r5_ack", div_ack, 1);
    check("r5_err", div_err, 0);
    check("r5_div", cur_div, 5);
    check("r5_clk", clk_out, 1);
    div_req = 1'b0;
    for (int i = 1; i < 10; i++) begin
      step();
      check("r5_pat", clk_out, exp5[i]);
      check("r5_noack", div_ack, 0);
    end

    div_req = 1'b1;
    div_val = 8'd1;
    step();
    check("ill1_ack", div_ack, 1);
    check("ill1_err", div_err, 1);
    check("ill1_div", cur_div, 5);
    check("ill1_clk", clk_out, 1);
    div_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      check("ill1_pat", clk_out, exp5[i]);
      check("ill1_noerr", div_err, 0);
    end

    div_req = 1'b1;
    div_val = 8'd0;
    step();
    check("ill0_ack", div_ack, 1);
    check("ill0_err", div_err, 1);
    check("ill0_div", cur_div, 5);
    check("ill0_clk", clk_out, 1);
    div_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      check("ill0_pat", clk_out, exp5[i]);
      check("ill0_div2", cur_div, 5);
    end

    div_req = 1'b1;
    div_val = 8'd255;
    step();
    check("max_ack", div_ack, 1);
    check("max_err", div_err, 0);
    check("max_div", cur_div, 255);
    check("max_clk0", clk_out, 1);
    div_req = 1'b0;
    for (int i = 1; i < 255; i++) begin
      step();
      check("max_pat", clk_out, (i < 128) ? 1 : 0);
    end
    step();
    check("max_wrap", clk_out, 1);

    // cnt=0 of ratio 255: boundary is 255 edges away
    div_req = 1'b1;
    div_val = 8'd6;
    n = 0;
    do begin
      step();
      n++;
    end while (!div_ack && n < 300);
    check("r6_ack", div_ack, 1);
    check("r6_lat", n, 255);
    check("r6_div", cur_div, 6);
    check("r6_clk", clk_out, 1);
    div_req = 1'b0;
    step();
    check("r6_clk1", clk_out, 1);

    div_req = 1'b1;
    div_val = 8'd4;
    rst     = 1'b1;
    step();
    check("mrst_clk", clk_out, 0);
    check("mrst_div", cur_div, 2);
    check("mrst_ack", div_ack, 0);
`ifdef CLK_DIV_TICK_EN
    check("mrst_tick", tick_out, 0);
`endif
    rst     = 1'b0;
    div_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mrst_pat", clk_out, exp_rs[i]);
      check("mrst_noack", div_ack, 0);
      check("mrst_div2", cur_div, 2);
    end

    div_req = 1'b1;
    div_val = 8'd2;
    step();
    check("same_ack", div_ack, 1);
    check("same_err", div_err, 0);
    check("same_div", cur_div, 2);
    check("same_clk", clk_out, 1);
    div_req = 1'b0;
    step();
    check("same_clk1", clk_out, 0);
    step();
    check("same_clk2", clk_out, 1);

    // cnt=0 of ratio 2: request waits one edge for the boundary
    div_req = 1'b1;
    div_val = 8'd3;
    step();
    check("r3_wait_ack", div_ack, 0);
    check("r3_wait_clk", clk_out, 0);
    step();
    check("r3_ack", div_ack, 1);
    check("r3_div", cur_div, 3);
    check("r3_clk", clk_out, 1);
`ifdef CLK_DIV_TICK_EN
    check("r3_tick", tick_out, 1);
`endif
    div_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("r3_pat", clk_out, exp3_clk[i]);
`ifdef CLK_DIV_TICK_EN
      check("r3_tpat", tick_out, exp3_tck[i]);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
